// File: rtl/irrigacao_pkg.sv
// ============================================================================
// Module      : irrigacao_pkg
// Description : Shared types and constants for the irrigation controller:
//               controller state encoding, water-level thermometer codes,
//               a level-validity check and a minutes-to-BCD helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irrigacao_pkg;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        ASPERSAO    = 3'd1,
        GOTEJAMENTO = 3'd2,
        ENCHENDO    = 3'd3,
        ERRO        = 3'd4
    } estado_t;

    // Water-level sensor thermometer codes
    localparam logic [2:0] NIVEL_VAZIO = 3'b000;
    localparam logic [2:0] NIVEL_BAIXO = 3'b001;
    localparam logic [2:0] NIVEL_MEDIO = 3'b011;
    localparam logic [2:0] NIVEL_CHEIO = 3'b111;

    // Only the four thermometer patterns are legal; anything else means a
    // broken sensor string.
    function automatic logic nivel_valido(input logic [2:0] nivel);
        return (nivel == NIVEL_VAZIO) || (nivel == NIVEL_BAIXO) ||
               (nivel == NIVEL_MEDIO) || (nivel == NIVEL_CHEIO);
    endfunction

    // Converts a 0..59 minute count to {tens, units} BCD.
    function automatic logic [7:0] minutos_para_bcd(input logic [5:0] minutos);
        logic [3:0] dezena;
        logic [3:0] unidade;
        dezena  = 4'(minutos / 6'd10);
        unidade = 4'(minutos % 6'd10);
        return {dezena, unidade};
    endfunction

endpackage : irrigacao_pkg

`default_nettype wire

// File: rtl/contador_regressivo_bcd.sv
// ============================================================================
// Module      : contador_regressivo_bcd
// Description : mm:ss BCD down counter. Loads carga_min:00, decrements by one
//               second per tick and saturates at 00:00.
//               Priority: reset > clear > load > tick.
// Ports       : clock, reset       - clock / synchronous active-high reset
//               load, carga_min    - load carga_min:00 (binary minutes 1..59)
//               clear              - force 00:00
//               tick               - decrement one second
//               dez_min..uni_seg   - BCD digits
//               zero_proximo       - count is exactly 00:01
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_regressivo_bcd
    import irrigacao_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [5:0] carga_min,
    input  logic       clear,
    input  logic       tick,
    output logic [3:0] dez_min,
    output logic [3:0] uni_min,
    output logic [3:0] dez_seg,
    output logic [3:0] uni_seg,
    output logic       zero_proximo
);

    logic       em_zero;
    logic [7:0] carga_bcd;

    assign carga_bcd    = minutos_para_bcd(carga_min);
    assign em_zero      = (dez_min == 4'd0) && (uni_min == 4'd0) &&
                          (dez_seg == 4'd0) && (uni_seg == 4'd0);
    assign zero_proximo = (dez_min == 4'd0) && (uni_min == 4'd0) &&
                          (dez_seg == 4'd0) && (uni_seg == 4'd1);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            dez_min <= 4'd0;
            uni_min <= 4'd0;
            dez_seg <= 4'd0;
            uni_seg <= 4'd0;
        end else if (load) begin
            dez_min <= carga_bcd[7:4];
            uni_min <= carga_bcd[3:0];
            dez_seg <= 4'd0;
            uni_seg <= 4'd0;
        end else if (tick && !em_zero) begin
            // Borrow ripples seconds-units -> seconds-tens -> minutes-units
            // -> minutes-tens; the em_zero guard keeps dez_min from wrapping.
            if (uni_seg != 4'd0) begin
                uni_seg <= uni_seg - 4'd1;
            end else begin
                uni_seg <= 4'd9;
                if (dez_seg != 4'd0) begin
                    dez_seg <= dez_seg - 4'd1;
                end else begin
                    dez_seg <= 4'd5;
                    if (uni_min != 4'd0) begin
                        uni_min <= uni_min - 4'd1;
                    end else begin
                        uni_min <= 4'd9;
                        dez_min <= dez_min - 4'd1;
                    end
                end
            end
        end
    end

endmodule : contador_regressivo_bcd

`default_nettype wire

// File: rtl/controle_irrigacao.sv
// ============================================================================
// Module      : controle_irrigacao
// Description : Irrigation controller FSM. Synchronises the humidity,
//               temperature and water-level sensors, chooses between
//               sprinkler, drip, tank filling and error, drives the valves
//               and alarm, and exposes the remaining irrigation time as
//               four BCD digits (mm:ss).
// Ports       : clock, reset          - clock / synchronous active-high reset
//               umSegundo             - 1-cycle pulse once per second
//               umidadeAr/Solo        - humidity sensors (async)
//               temperatura           - high-temperature sensor (async)
//               nivelDagua[2:0]       - thermometer-coded level (async)
//               valvulaEntrada, aspersor, gotejamento, alarme - registered
//               dezenaMinuto..unidadeSegundos - remaining time, BCD
// Config      : IRRIGACAO_ALARME_PISCA_EN - when defined, alarme toggles on
//               every umSegundo while in ERRO (starting at 1); otherwise it
//               is held at 1 for the whole of ERRO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controle_irrigacao
    import irrigacao_pkg::*;
#(
    parameter int TEMPO_ASPERSAO_MIN    = 15,
    parameter int TEMPO_GOTEJAMENTO_MIN = 30,
    parameter int ERRO_TICKS            = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       umSegundo,
    input  logic       umidadeAr,
    input  logic       umidadeSolo,
    input  logic       temperatura,
    input  logic [2:0] nivelDagua,
    output logic       valvulaEntrada,
    output logic       aspersor,
    output logic       gotejamento,
    output logic       alarme,
    output logic [3:0] dezenaMinuto,
    output logic [3:0] unidadeMinuto,
    output logic [3:0] dezenaSegundos,
    output logic [3:0] unidadeSegundos
);

    localparam logic [5:0] CARGA_ASPERSAO    = 6'(TEMPO_ASPERSAO_MIN);
    localparam logic [5:0] CARGA_GOTEJAMENTO = 6'(TEMPO_GOTEJAMENTO_MIN);
    localparam logic [3:0] ERRO_ULTIMO       = 4'(ERRO_TICKS - 1);

    // ------------------------------------------------------------------
    // Two-flop synchroniser: {umidadeAr, umidadeSolo, temperatura, nivel}
    // ------------------------------------------------------------------
    logic [5:0] sync_meta;
    logic [5:0] sync_est;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 6'd0;
            sync_est  <= 6'd0;
        end else begin
            sync_meta <= {umidadeAr, umidadeSolo, temperatura, nivelDagua};
            sync_est  <= sync_meta;
        end
    end

    logic       ar_s;
    logic       solo_s;
    logic       temp_s;
    logic [2:0] nivel_s;
    logic       nivel_ok;

    assign ar_s     = sync_est[5];
    assign solo_s   = sync_est[4];
    assign temp_s   = sync_est[3];
    assign nivel_s  = sync_est[2:0];
    assign nivel_ok = nivel_valido(nivel_s);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    estado_t    estado;
    estado_t    estado_prox;
    logic [3:0] erro_cnt;
    logic       cnt_load;
    logic [5:0] cnt_carga;
    logic       cnt_clear;
    logic       cnt_tick;
    logic       zero_proximo;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        cnt_load    = 1'b0;
        cnt_carga   = CARGA_ASPERSAO;
        cnt_tick    = 1'b0;

        unique case (estado)
            OCIOSO: begin
                if (!nivel_ok) begin
                    estado_prox = ERRO;
                end else if (nivel_s == NIVEL_VAZIO) begin
                    estado_prox = ENCHENDO;
                end else if (!solo_s) begin
                    cnt_load = 1'b1;
                    // Sprinkling needs at least a medium tank and hot or dry air
                    if (((nivel_s == NIVEL_MEDIO) || (nivel_s == NIVEL_CHEIO)) &&
                        (temp_s || !ar_s)) begin
                        estado_prox = ASPERSAO;
                        cnt_carga   = CARGA_ASPERSAO;
                    end else begin
                        estado_prox = GOTEJAMENTO;
                        cnt_carga   = CARGA_GOTEJAMENTO;
                    end
                end
            end

            ASPERSAO, GOTEJAMENTO: begin
                // Aborts are checked first so a coincident umSegundo is
                // ignored and never decrements the display.
                if (!nivel_ok) begin
                    estado_prox = ERRO;
                end else if (nivel_s == NIVEL_VAZIO) begin
                    estado_prox = ENCHENDO;
                end else if (solo_s) begin
                    estado_prox = OCIOSO;
                end else begin
                    cnt_tick = umSegundo;
                    if (umSegundo && zero_proximo) begin
                        estado_prox = OCIOSO;
                    end
                end
            end

            ENCHENDO: begin
                if (!nivel_ok) begin
                    estado_prox = ERRO;
                end else if (nivel_s == NIVEL_CHEIO) begin
                    estado_prox = OCIOSO;
                end
            end

            ERRO: begin
                if (nivel_ok && umSegundo && (erro_cnt == ERRO_ULTIMO)) begin
                    estado_prox = OCIOSO;
                end
            end

            default: estado_prox = OCIOSO;
        endcase
    end

    // Display is held at 00:00 whenever the next state is not irrigating;
    // this also produces 00:00 on the final countdown edge.
    assign cnt_clear = !((estado_prox == ASPERSAO) || (estado_prox == GOTEJAMENTO));

    // ERRO recovery counter: consecutive valid-level seconds
    always_ff @(posedge clock) begin
        if (reset) begin
            erro_cnt <= 4'd0;
        end else if ((estado != ERRO) || (estado_prox != ERRO) || !nivel_ok) begin
            erro_cnt <= 4'd0;
        end else if (umSegundo) begin
            erro_cnt <= erro_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the next state so they change on
    // the same edge as the state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            valvulaEntrada <= 1'b0;
            aspersor       <= 1'b0;
            gotejamento    <= 1'b0;
            alarme         <= 1'b0;
        end else begin
            valvulaEntrada <= (estado_prox == ENCHENDO);
            aspersor       <= (estado_prox == ASPERSAO);
            gotejamento    <= (estado_prox == GOTEJAMENTO);
`ifdef IRRIGACAO_ALARME_PISCA_EN
            if (estado_prox != ERRO) begin
                alarme <= 1'b0;
            end else if (estado != ERRO) begin
                alarme <= 1'b1;
            end else if (umSegundo) begin
                alarme <= ~alarme;
            end
`else
            alarme <= (estado_prox == ERRO);
`endif
        end
    end

    contador_regressivo_bcd u_contador (
        .clock        (clock),
        .reset        (reset),
        .load         (cnt_load),
        .carga_min    (cnt_carga),
        .clear        (cnt_clear),
        .tick         (cnt_tick),
        .dez_min      (dezenaMinuto),
        .uni_min      (unidadeMinuto),
        .dez_seg      (dezenaSegundos),
        .uni_seg      (unidadeSegundos),
        .zero_proximo (zero_proximo)
    );

endmodule : controle_irrigacao

`default_nettype wire

// File: tb/tb_controle_irrigacao.sv
// ============================================================================
// Module      : tb_controle_irrigacao
// Description : Directed self-checking bench for controle_irrigacao, using
//               short irrigation times (1 min sprinkler, 2 min drip).
//               Expected alarme values follow IRRIGACAO_ALARME_PISCA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controle_irrigacao;

    logic       clock = 1'b0;
    logic       reset;
    logic       umSegundo;
    logic       umidadeAr;
    logic       umidadeSolo;
    logic       temperatura;
    logic [2:0] nivelDagua;
    logic       valvulaEntrada;
    logic       aspersor;
    logic       gotejamento;
    logic       alarme;
    logic [3:0] dezenaMinuto;
    logic [3:0] unidadeMinuto;
    logic [3:0] dezenaSegundos;
    logic [3:0] unidadeSegundos;

`ifdef IRRIGACAO_ALARME_PISCA_EN
    localparam bit PISCA = 1'b1;
`else
    localparam bit PISCA = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    controle_irrigacao #(
        .TEMPO_ASPERSAO_MIN    (1),
        .TEMPO_GOTEJAMENTO_MIN (2),
        .ERRO_TICKS            (3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .umSegundo       (umSegundo),
        .umidadeAr       (umidadeAr),
        .umidadeSolo     (umidadeSolo),
        .temperatura     (temperatura),
        .nivelDagua      (nivelDagua),
        .valvulaEntrada  (valvulaEntrada),
        .aspersor        (aspersor),
        .gotejamento     (gotejamento),
        .alarme          (alarme),
        .dezenaMinuto    (dezenaMinuto),
        .unidadeMinuto   (unidadeMinuto),
        .dezenaSegundos  (dezenaSegundos),
        .unidadeSegundos (unidadeSegundos)
    );

    always #5 clock = ~clock;

    // {valvulaEntrada, aspersor, gotejamento, alarme}
    logic [3:0]  valv;
    logic [15:0] disp;
    assign valv = {valvulaEntrada, aspersor, gotejamento, alarme};
    assign disp = {dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // n consecutive one-cycle umSegundo pulses.
    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            umSegundo = 1'b1;
            @(posedge clock);
            #1;
            umSegundo = 1'b0;
        end
    endtask

    initial begin
        reset       = 1'b1;
        umSegundo   = 1'b0;
        umidadeAr   = 1'b1;
        umidadeSolo = 1'b1;
        temperatura = 1'b0;
        nivelDagua  = 3'b111;
        step(3);
        check("rst_valves", 16'(valv), 16'h0);
        check("rst_disp", disp, 16'h0000);
        reset = 1'b0;
        step(4);
        check("idle_wet", 16'(valv), 16'h0);

        // Sprinkler: soil dry, air dry, full tank
        umidadeSolo = 1'b0;
        umidadeAr   = 1'b0;
        step(2);
        check("latency_2edges", 16'(valv), 16'h0);
        step(1);
        check("asp_valves", 16'(valv), 16'b0100);
        check("asp_disp", disp, 16'h0100);
        pulse(1);
        check("asp_1pulse", disp, 16'h0059);
        pulse(58);
        check("asp_59pulse", disp, 16'h0001);
        check("asp_still_on", 16'(valv), 16'b0100);
        pulse(1);
        check("asp_end_disp", disp, 16'h0000);
        check("asp_end_valves", 16'(valv), 16'h0);
        step(1);
        check("asp_reenter", disp, 16'h0100);
        umidadeSolo = 1'b1;
        step(3);
        check("soil_abort_valves", 16'(valv), 16'h0);
        check("soil_abort_disp", disp, 16'h0000);

        // Drip: soil dry, air humid, temp low, low tank
        umidadeAr   = 1'b1;
        temperatura = 1'b0;
        nivelDagua  = 3'b001;
        umidadeSolo = 1'b0;
        step(3);
        check("got_valves", 16'(valv), 16'b0010);
        check("got_disp", disp, 16'h0200);
        pulse(1);
        check("got_1pulse", disp, 16'h0159);
        pulse(59);
        check("got_60pulse", disp, 16'h0100);
        umidadeSolo = 1'b1;
        step(3);
        check("got_abort", 16'(valv), 16'h0);

        // Empty tank coinciding with umSegundo during sprinkling
        umidadeSolo = 1'b0;
        umidadeAr   = 1'b0;
        nivelDagua  = 3'b111;
        step(3);
        check("asp2_valves", 16'(valv), 16'b0100);
        pulse(3);
        check("asp2_disp", disp, 16'h0057);
        nivelDagua = 3'b000;
        step(2);
        pulse(1);
        check("fill_valves", 16'(valv), 16'b1000);
        check("fill_disp", disp, 16'h0000);
        nivelDagua  = 3'b111;
        umidadeSolo = 1'b1;
        step(3);
        check("fill_done", 16'(valv), 16'h0);

        // Invalid level -> ERRO and recovery
        nivelDagua = 3'b101;
        step(3);
        check("erro_entry", 16'(valv), 16'b0001);
        nivelDagua = 3'b111;
        step(3);
        pulse(1);
        check("erro_p1", 16'(valv), PISCA ? 16'b0000 : 16'b0001);
        pulse(1);
        check("erro_p2", 16'(valv), 16'b0001);
        nivelDagua = 3'b010;
        step(3);
        pulse(1);
        check("erro_invalid", 16'(valv), PISCA ? 16'b0000 : 16'b0001);
        nivelDagua = 3'b111;
        step(3);
        pulse(2);
        check("erro_two_valid", 16'(valv), PISCA ? 16'b0000 : 16'b0001);
        pulse(1);
        check("erro_exit", 16'(valv), 16'h0);
        step(2);
        check("erro_exit_idle", 16'(valv), 16'h0);

        // Drip with dry air but low tank, then reset at 00:37
        umidadeSolo = 1'b0;
        umidadeAr   = 1'b0;
        nivelDagua  = 3'b001;
        step(3);
        check("got2_valves", 16'(valv), 16'b0010);
        pulse(83);
        check("got2_disp", disp, 16'h0037);
        reset = 1'b1;
        step(1);
        check("midrst_valves", 16'(valv), 16'h0);
        check("midrst_disp", disp, 16'h0000);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_controle_irrigacao

`default_nettype wire
